// File: rtl/alu_share_arb_if.sv
// ---------------------------------------------------------------------------
// alu_share_arb_if
//   Bundles the signals around alu_share_arb: two request channels, two
//   response channels and the link to the shared combinational ALU.
//   slave  : view taken by alu_share_arb
//   master : view taken by the requesters and the shared ALU
// Signals
//   reqN_valid/ready/a/b/op   request channel N (N=0,1)
//   rspN_valid/ready/res/zero response channel N
//   rspN_err                  illegal-opcode flag (only with ALU_OPCHK_EN)
//   alu_a/b/op, alu_res/zero  shared ALU operands and results
// Configuration macro: ALU_OPCHK_EN
// ---------------------------------------------------------------------------
interface alu_share_arb_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [31:0] req0_a;
   logic [31:0] req0_b;
   logic [3:0]  req0_op;
   logic        req1_valid;
   logic        req1_ready;
   logic [31:0] req1_a;
   logic [31:0] req1_b;
   logic [3:0]  req1_op;

   logic        rsp0_valid;
   logic        rsp0_ready;
   logic [31:0] rsp0_res;
   logic        rsp0_zero;
   logic        rsp1_valid;
   logic        rsp1_ready;
   logic [31:0] rsp1_res;
   logic        rsp1_zero;
`ifdef ALU_OPCHK_EN
   logic        rsp0_err;
   logic        rsp1_err;
`endif

   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_op;
   logic [31:0] alu_res;
   logic        alu_zero;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp0_res, rsp0_zero,
      output rsp1_valid, rsp1_res, rsp1_zero,
      input  rsp0_ready, rsp1_ready,
      output alu_a, alu_b, alu_op,
      input  alu_res, alu_zero
`ifdef ALU_OPCHK_EN
      , output rsp0_err, rsp1_err
`endif
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp0_res, rsp0_zero,
      input  rsp1_valid, rsp1_res, rsp1_zero,
      output rsp0_ready, rsp1_ready,
      input  alu_a, alu_b, alu_op,
      output alu_res, alu_zero
`ifdef ALU_OPCHK_EN
      , input rsp0_err, rsp1_err
`endif
   );
endinterface

// File: rtl/alu_share_arb.sv
// ---------------------------------------------------------------------------
// alu_share_arb
//   Shares one combinational 32-bit ALU between two requesters. A round-robin
//   arbiter picks a requester in IDLE, operands are registered and held on the
//   ALU for EXEC_CYCLES cycles, the result/zero are registered and returned to
//   the owner in RESP until it is taken.
// Parameters
//   RR_INIT      requester that wins the first tie after reset (0 or 1)
//   EXEC_CYCLES  cycles the ALU inputs are held before capture (1..4)
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_share_arb_if.slave: request, response and ALU signals
// Configuration macro: ALU_OPCHK_EN
//   Defined  : rspN_err is driven; ops 3,5,8,10,11 bypass the ALU and return
//              res=0, zero=0, err=1.
//   Undefined: every opcode is executed by the ALU.
// ---------------------------------------------------------------------------
module alu_share_arb #(
   parameter int unsigned RR_INIT     = 0,
   parameter int unsigned EXEC_CYCLES = 1
) (
   input logic            clk,
   input logic            rst_n,
   alu_share_arb_if.slave bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [1:0] CNT_INIT  = 2'(EXEC_CYCLES - 1);
   localparam logic       PRIO_INIT = 1'(RR_INIT);

   logic [1:0]  state_q, state_d;
   logic        owner_q, owner_d;
   logic        prio_q,  prio_d;
   logic [1:0]  cnt_q,   cnt_d;
   logic [31:0] opa_q,   opa_d;
   logic [31:0] opb_q,   opb_d;
   logic [3:0]  op_q,    op_d;
   logic [31:0] res_q,   res_d;
   logic        zero_q,  zero_d;
`ifdef ALU_OPCHK_EN
   logic        err_q,   err_d;
`endif

   logic        grant;
   logic        in_idle;
   logic        accept;
   logic        own_rsp_ready;
   logic [31:0] sel_a;
   logic [31:0] sel_b;
   logic [3:0]  sel_op;

`ifdef ALU_OPCHK_EN
   function automatic logic op_illegal(input logic [3:0] op);
      case (op)
         4'd3, 4'd5, 4'd8, 4'd10, 4'd11: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction
`endif

   // Tie goes to prio_q; otherwise the lone valid requester wins.
   always_comb begin
      if (bus.req0_valid && bus.req1_valid) grant = prio_q;
      else                                  grant = bus.req1_valid;
   end

   // Ready is gated by rst_n so it is low for the whole reset, even with
   // valid requests present while the state register reads IDLE.
   assign in_idle        = rst_n && (state_q == IDLE);
   assign bus.req0_ready = in_idle && bus.req0_valid && !grant;
   assign bus.req1_ready = in_idle && bus.req1_valid &&  grant;
   assign accept         = bus.req0_ready || bus.req1_ready;

   assign sel_a  = grant ? bus.req1_a  : bus.req0_a;
   assign sel_b  = grant ? bus.req1_b  : bus.req0_b;
   assign sel_op = grant ? bus.req1_op : bus.req0_op;

   assign own_rsp_ready = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      prio_d  = prio_q;
      cnt_d   = cnt_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      op_d    = op_q;
      res_d   = res_q;
      zero_d  = zero_q;
`ifdef ALU_OPCHK_EN
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               opa_d   = sel_a;
               opb_d   = sel_b;
               op_d    = sel_op;
               owner_d = grant;
               cnt_d   = CNT_INIT;
               state_d = EXEC;
`ifdef ALU_OPCHK_EN
               err_d = op_illegal(sel_op);
               if (op_illegal(sel_op)) begin
                  res_d   = '0;
                  zero_d  = 1'b0;
                  state_d = RESP;
               end
`endif
            end
         end
         EXEC: begin
            if (cnt_q != 2'd0) begin
               cnt_d = cnt_q - 2'd1;
            end else begin
               res_d   = bus.alu_res;
               zero_d  = bus.alu_zero;
               state_d = RESP;
            end
         end
         RESP: begin
            if (own_rsp_ready) begin
               state_d = IDLE;
               prio_d  = ~owner_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         prio_q  <= PRIO_INIT;
         cnt_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         op_q    <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
`ifdef ALU_OPCHK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         prio_q  <= prio_d;
         cnt_q   <= cnt_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         op_q    <= op_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
`ifdef ALU_OPCHK_EN
         err_q   <= err_d;
`endif
      end
   end

   // Operand registers feed the ALU directly, so they hold in IDLE and RESP.
   assign bus.alu_a  = opa_q;
   assign bus.alu_b  = opb_q;
   assign bus.alu_op = op_q;

   assign bus.rsp0_valid = (state_q == RESP) && !owner_q;
   assign bus.rsp1_valid = (state_q == RESP) &&  owner_q;
   assign bus.rsp0_res   = res_q;
   assign bus.rsp1_res   = res_q;
   assign bus.rsp0_zero  = zero_q;
   assign bus.rsp1_zero  = zero_q;
`ifdef ALU_OPCHK_EN
   assign bus.rsp0_err   = err_q;
   assign bus.rsp1_err   = err_q;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arb
//   Directed bench for alu_share_arb. Two instances: u_dut_a (EXEC_CYCLES=1,
//   RR_INIT=0) and u_dut_b (EXEC_CYCLES=3). Each has its own ALU model; the
//   model of u_dut_b can be overridden to show late ALU changes are ignored.
// Configuration macro: ALU_OPCHK_EN (enables the illegal-opcode steps)
// ---------------------------------------------------------------------------
module tb_alu_share_arb;

   logic        clk;
   logic        rst_n;
   logic        ovr_b;
   logic [31:0] ovr_val;
   int          n_checks;
   int          n_errors;
   logic        own;

   alu_share_arb_if ifa ();
   alu_share_arb_if ifb ();

   alu_share_arb #(.RR_INIT(0), .EXEC_CYCLES(1)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifa)
   );

   alu_share_arb #(.RR_INIT(0), .EXEC_CYCLES(3)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
      case (op)
         4'd0:    return a & b;
         4'd1:    return a | b;
         4'd2:    return a + b;
         4'd6:    return a - b;
         4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd12:   return ~(a | b);
         default: return a ^ b;
      endcase
   endfunction

   always_comb begin
      logic [31:0] r;
      r = alu_f(ifa.alu_a, ifa.alu_b, ifa.alu_op);
      ifa.alu_res  = r;
      ifa.alu_zero = (r == 32'd0);
   end

   always_comb begin
      logic [31:0] r;
      r = ovr_b ? ovr_val : alu_f(ifb.alu_a, ifb.alu_b, ifb.alu_op);
      ifb.alu_res  = r;
      ifb.alu_zero = (r == 32'd0);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      ovr_b    = 1'b0;
      ovr_val  = '0;
      own      = 1'b0;
      ifa.req0_valid = 0; ifa.req0_a = '0; ifa.req0_b = '0; ifa.req0_op = '0;
      ifa.req1_valid = 0; ifa.req1_a = '0; ifa.req1_b = '0; ifa.req1_op = '0;
      ifa.rsp0_ready = 0; ifa.rsp1_ready = 0;
      ifb.req0_valid = 0; ifb.req0_a = '0; ifb.req0_b = '0; ifb.req0_op = '0;
      ifb.req1_valid = 0; ifb.req1_a = '0; ifb.req1_b = '0; ifb.req1_op = '0;
      ifb.rsp0_ready = 0; ifb.rsp1_ready = 0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rsp0_valid", ifa.rsp0_valid, 0);
      chk("rst_rsp1_valid", ifa.rsp1_valid, 0);
      chk("rst_alu_a", ifa.alu_a, 0);
      chk("rst_alu_op", ifa.alu_op, 0);
      chk("rst_res", ifa.rsp0_res, 0);
`ifdef ALU_OPCHK_EN
      chk("rst_err", ifa.rsp0_err, 0);
`endif
      ifa.req0_valid = 1; ifa.req1_valid = 1;
      #1;
      chk("rst_ready0", ifa.req0_ready, 0);
      chk("rst_ready1", ifa.req1_ready, 0);
      ifa.req0_valid = 0; ifa.req1_valid = 0;
      rst_n = 1'b1;
      cyc();

      // T2: req0 alone, 5+3
      ifa.req0_a = 32'd5; ifa.req0_b = 32'd3; ifa.req0_op = 4'd2; ifa.req0_valid = 1;
      #1;
      chk("t2_ready0", ifa.req0_ready, 1);
      chk("t2_ready1", ifa.req1_ready, 0);
      cyc();
      ifa.req0_valid = 0;
      #1;
      chk("t2_exec_rsp0_valid", ifa.rsp0_valid, 0);
      chk("t2_alu_a", ifa.alu_a, 32'd5);
      chk("t2_alu_b", ifa.alu_b, 32'd3);
      chk("t2_alu_op", ifa.alu_op, 32'd2);
      cyc();
      chk("t2_rsp0_valid", ifa.rsp0_valid, 1);
      chk("t2_rsp1_valid", ifa.rsp1_valid, 0);
      chk("t2_res", ifa.rsp0_res, 32'd8);
      chk("t2_zero", ifa.rsp0_zero, 0);
      ifa.rsp0_ready = 1;
      cyc();
      chk("t2_done_valid", ifa.rsp0_valid, 0);
      chk("t2_alu_a_hold", ifa.alu_a, 32'd5);
      ifa.rsp0_ready = 0;

      // T4: req1 subtract to zero, stalled response (prio now 1)
      ifa.req0_a = 32'd1; ifa.req0_b = 32'd1; ifa.req0_op = 4'd2; ifa.req0_valid = 1;
      ifa.req1_a = 32'h1234; ifa.req1_b = 32'h1234; ifa.req1_op = 4'd6; ifa.req1_valid = 1;
      #1;
      chk("t4_ready1", ifa.req1_ready, 1);
      chk("t4_ready0", ifa.req0_ready, 0);
      cyc();
      ifa.req1_valid = 0;
      #1;
      chk("t4_exec_ready0", ifa.req0_ready, 0);
      cyc();
      for (int i = 0; i < 5; i++) begin
         chk("t4_rsp1_valid", ifa.rsp1_valid, 1);
         chk("t4_rsp0_valid", ifa.rsp0_valid, 0);
         chk("t4_res", ifa.rsp1_res, 32'd0);
         chk("t4_zero", ifa.rsp1_zero, 1);
         chk("t4_stall_ready0", ifa.req0_ready, 0);
         cyc();
      end
      chk("t4_still_valid", ifa.rsp1_valid, 1);
      // Prepare T3 operands; release the stall
      ifa.req0_a = 32'd10; ifa.req0_b = 32'd4; ifa.req0_op = 4'd6;
      ifa.req1_a = 32'hF0; ifa.req1_b = 32'h0F; ifa.req1_op = 4'd1; ifa.req1_valid = 1;
      ifa.rsp0_ready = 1; ifa.rsp1_ready = 1;
      cyc();

      // T3: both valid every cycle, grants alternate 0,1,0,1 every 3 cycles
      for (int g = 0; g < 4; g++) begin
         own = (g % 2 == 1);
         chk("t3_ready0", ifa.req0_ready, !own);
         chk("t3_ready1", ifa.req1_ready, own);
         cyc();
         chk("t3_exec_ready0", ifa.req0_ready, 0);
         chk("t3_exec_ready1", ifa.req1_ready, 0);
         cyc();
         chk("t3_rsp0_valid", ifa.rsp0_valid, !own);
         chk("t3_rsp1_valid", ifa.rsp1_valid, own);
         chk("t3_res", own ? ifa.rsp1_res : ifa.rsp0_res, own ? 32'hFF : 32'd6);
         cyc();
      end
      ifa.req0_valid = 0; ifa.req1_valid = 0;
      ifa.rsp0_ready = 0; ifa.rsp1_ready = 0;

      // Valid dropped in IDLE before an edge grants nothing
      ifa.req1_a = 32'h99; ifa.req1_valid = 1;
      #1;
      chk("drop_ready1_seen", ifa.req1_ready, 1);
      ifa.req1_valid = 0;
      #1;
      chk("drop_ready1_gone", ifa.req1_ready, 0);
      cyc();
      chk("drop_alu_a", ifa.alu_a, 32'hF0);
      chk("drop_rsp1_valid", ifa.rsp1_valid, 0);
      ifa.req0_valid = 1;
      #1;
      chk("drop_still_idle", ifa.req0_ready, 1);
      ifa.req0_valid = 0;
      cyc();
      cyc();
      chk("drop_no_rsp0", ifa.rsp0_valid, 0);

      // Opcode 5: illegal with the checker, executed without it
      ifa.req0_a = 32'd3; ifa.req0_b = 32'd1; ifa.req0_op = 4'd5; ifa.req0_valid = 1;
      ifa.rsp0_ready = 1;
      cyc();
      ifa.req0_valid = 0;
      #1;
`ifdef ALU_OPCHK_EN
      chk("t6_illegal_valid", ifa.rsp0_valid, 1);
      chk("t6_illegal_res", ifa.rsp0_res, 32'd0);
      chk("t6_illegal_zero", ifa.rsp0_zero, 0);
      chk("t6_illegal_err", ifa.rsp0_err, 1);
      cyc();
      ifa.req0_a = 32'hF0; ifa.req0_b = 32'h3C; ifa.req0_op = 4'd0; ifa.req0_valid = 1;
      cyc();
      ifa.req0_valid = 0;
      #1;
      chk("t6_legal_exec", ifa.rsp0_valid, 0);
      cyc();
      chk("t6_legal_valid", ifa.rsp0_valid, 1);
      chk("t6_legal_res", ifa.rsp0_res, 32'h30);
      chk("t6_legal_err", ifa.rsp0_err, 0);
      chk("t6_legal_zero", ifa.rsp0_zero, 0);
      cyc();
`else
      chk("op5_exec", ifa.rsp0_valid, 0);
      cyc();
      chk("op5_valid", ifa.rsp0_valid, 1);
      chk("op5_res", ifa.rsp0_res, 32'd2);
      chk("op5_zero", ifa.rsp0_zero, 0);
      cyc();
`endif
      ifa.rsp0_ready = 0;
      chk("op_done_valid", ifa.rsp0_valid, 0);

      // T1: reset asserted mid-EXEC (prio is 1 here; RR_INIT=0 must win after)
      ifa.req0_a = 32'd1; ifa.req0_b = 32'd1; ifa.req0_op = 4'd2; ifa.req0_valid = 1;
      cyc();
      ifa.req0_valid = 1; ifa.req1_valid = 1;
      #1;
      chk("t1_in_exec", ifa.req0_ready, 0);
      rst_n = 1'b0;
      #1;
      chk("t1_rst_ready0", ifa.req0_ready, 0);
      chk("t1_rst_ready1", ifa.req1_ready, 0);
      chk("t1_rst_rsp0_valid", ifa.rsp0_valid, 0);
      chk("t1_rst_rsp1_valid", ifa.rsp1_valid, 0);
      chk("t1_rst_alu_a", ifa.alu_a, 32'd0);
      chk("t1_rst_alu_op", ifa.alu_op, 32'd0);
      cyc();
      rst_n = 1'b1;
      #1;
      chk("t1_rr_init_ready0", ifa.req0_ready, 1);
      chk("t1_rr_init_ready1", ifa.req1_ready, 0);
      ifa.req0_valid = 0; ifa.req1_valid = 0;
      cyc();
      cyc();
      chk("t1_no_stale_rsp0", ifa.rsp0_valid, 0);
      chk("t1_no_stale_rsp1", ifa.rsp1_valid, 0);

      // T5: EXEC_CYCLES=3 holds ALU inputs 3 cycles; late ALU change ignored
      ifb.req0_a = 32'h11; ifb.req0_b = 32'h22; ifb.req0_op = 4'd1; ifb.req0_valid = 1;
      #1;
      chk("t5_ready0", ifb.req0_ready, 1);
      cyc();
      ifb.req0_valid = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t5_alu_a", ifb.alu_a, 32'h11);
         chk("t5_alu_b", ifb.alu_b, 32'h22);
         chk("t5_alu_op", ifb.alu_op, 32'd1);
         chk("t5_exec_valid", ifb.rsp0_valid, 0);
         cyc();
      end
      chk("t5_rsp0_valid", ifb.rsp0_valid, 1);
      chk("t5_res", ifb.rsp0_res, 32'h33);
      chk("t5_zero", ifb.rsp0_zero, 0);
      ovr_b = 1'b1; ovr_val = 32'hDEAD;
      cyc();
      chk("t5_res_held", ifb.rsp0_res, 32'h33);
      chk("t5_valid_held", ifb.rsp0_valid, 1);
      ovr_b = 1'b0;
      ifb.rsp0_ready = 1;
      cyc();
      chk("t5_done_valid", ifb.rsp0_valid, 0);
      ifb.rsp0_ready = 0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
